// File: rtl/fc_ibuf_stream_if.sv
// Handshake and bus bundle for fc_ibuf_stream: write-beat side plus bit-plane output side.
interface fc_ibuf_stream_if #(
  parameter int DATA_SIZE    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int FIFO_LENGTH  = 32,
  parameter int BUS_WIDTH    = 16
);
  localparam int ELEMENTS = NUM_CHANNELS * FIFO_LENGTH;
  localparam int NUM_ADDR = (ELEMENTS + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int ADDR_W   = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
  localparam int PLANE_W  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  logic                              i_valid;
  logic                              o_ready;
  logic [NUM_CHANNELS*DATA_SIZE-1:0] i_data;
  logic                              i_clear;
  logic                              o_valid;
  logic                              i_ready;
  logic [BUS_WIDTH-1:0]              o_data;
  logic [ADDR_W-1:0]                 o_addr;
  logic [PLANE_W-1:0]                o_plane;
  logic                              o_msb_plane;
  logic                              o_last;

  modport slave (
    input  i_valid, i_data, i_clear, i_ready,
    output o_ready, o_valid, o_data, o_addr, o_plane, o_msb_plane, o_last
  );

  modport master (
    output i_valid, i_data, i_clear, i_ready,
    input  o_ready, o_valid, o_data, o_addr, o_plane, o_msb_plane, o_last
  );
endinterface

// File: rtl/fc_ibuf_stream.sv
// Activation input buffer: fills FIFO_LENGTH beats of NUM_CHANNELS elements, then streams
// them out bit-plane by bit-plane (LSB first) as BUS_WIDTH-bit words.
module fc_ibuf_stream #(
  parameter int DATA_SIZE    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int FIFO_LENGTH  = 32,
  parameter int BUS_WIDTH    = 16
) (
  input  logic              clk,
  input  logic              rstn,
  fc_ibuf_stream_if.slave   bus
);
  localparam int ELEMENTS = NUM_CHANNELS * FIFO_LENGTH;
  localparam int NUM_ADDR = (ELEMENTS + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int ADDR_W   = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
  localparam int PLANE_W  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam int BEAT_W   = (FIFO_LENGTH > 1) ? $clog2(FIFO_LENGTH) : 1;
  localparam int MEM_W    = ELEMENTS * DATA_SIZE;

  typedef enum logic [0:0] {
    S_FILL   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [BEAT_W-1:0]    r_beat, w_beat_nxt;
  logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
  logic [PLANE_W-1:0]   r_plane, w_plane_nxt;
  logic [MEM_W-1:0]     r_mem, w_mem_nxt;
  logic [BUS_WIDTH-1:0] r_data;
  logic                 r_msb;
  logic                 r_last;
  logic                 w_accept;
  logic                 w_hs;
  logic                 w_stream_nxt;

  // Gather bit `plane` of the BUS_WIDTH elements addressed by `addr`; indices past the end read 0.
  function automatic logic [BUS_WIDTH-1:0] plane_word(
    input logic [MEM_W-1:0]   mem,
    input logic [ADDR_W-1:0]  addr,
    input logic [PLANE_W-1:0] plane
  );
    logic [BUS_WIDTH-1:0] word;
    int                   idx;
    word = '0;
    for (int b = 0; b < BUS_WIDTH; b++) begin
      idx = int'(addr) * BUS_WIDTH + b;
      if (idx < ELEMENTS) word[b] = mem[idx*DATA_SIZE + int'(plane)];
      else                word[b] = 1'b0;
    end
    return word;
  endfunction

  // Next-state, counters and storage write; i_clear overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_addr_nxt  = r_addr;
    w_plane_nxt = r_plane;
    w_mem_nxt   = r_mem;
    w_accept    = (r_state == S_FILL) && bus.i_valid;
    w_hs        = (r_state == S_STREAM) && bus.i_ready;
    if (bus.i_clear) begin
      w_state_nxt = S_FILL;
      w_beat_nxt  = '0;
      w_addr_nxt  = '0;
      w_plane_nxt = '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
              w_mem_nxt[(int'(r_beat)*NUM_CHANNELS + c)*DATA_SIZE +: DATA_SIZE] =
                bus.i_data[c*DATA_SIZE +: DATA_SIZE];
            end
            if (r_beat == BEAT_W'(FIFO_LENGTH-1)) begin
              w_state_nxt = S_STREAM;
              w_beat_nxt  = '0;
              w_addr_nxt  = '0;
              w_plane_nxt = '0;
            end else begin
              w_beat_nxt = r_beat + BEAT_W'(1);
            end
          end else begin
            w_beat_nxt = r_beat;
          end
        end
        S_STREAM: begin
          if (w_hs) begin
            if (r_addr == ADDR_W'(NUM_ADDR-1)) begin
              w_addr_nxt = '0;
              if (r_plane == PLANE_W'(DATA_SIZE-1)) begin
                w_state_nxt = S_FILL;
                w_plane_nxt = '0;
              end else begin
                w_plane_nxt = r_plane + PLANE_W'(1);
              end
            end else begin
              w_addr_nxt = r_addr + ADDR_W'(1);
            end
          end else begin
            w_addr_nxt = r_addr;
          end
        end
        default: begin
          w_state_nxt = S_FILL;
        end
      endcase
    end
  end

  assign w_stream_nxt = (w_state_nxt == S_STREAM);

  // State, counters and output word registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_FILL;
      r_beat  <= '0;
      r_addr  <= '0;
      r_plane <= '0;
      r_data  <= '0;
      r_msb   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_addr  <= w_addr_nxt;
      r_plane <= w_plane_nxt;
      // Word is precomputed from next-cycle storage so o_data is valid with o_valid.
      r_data  <= w_stream_nxt ? plane_word(w_mem_nxt, w_addr_nxt, w_plane_nxt) : '0;
      r_msb   <= w_stream_nxt && (w_plane_nxt == PLANE_W'(DATA_SIZE-1));
      r_last  <= w_stream_nxt && (w_plane_nxt == PLANE_W'(DATA_SIZE-1))
                              && (w_addr_nxt == ADDR_W'(NUM_ADDR-1));
    end
  end

  // Element storage; contents are irrelevant until fully written.
  always_ff @(posedge clk) begin
    r_mem <= w_mem_nxt;
  end

  assign bus.o_ready     = (r_state == S_FILL);
  assign bus.o_valid     = (r_state == S_STREAM);
  assign bus.o_data      = r_data;
  assign bus.o_addr      = r_addr;
  assign bus.o_plane     = r_plane;
  assign bus.o_msb_plane = r_msb;
  assign bus.o_last      = r_last;
endmodule

// File: tb/tb_fc_ibuf_stream.sv
// Bench for fc_ibuf_stream: queue-based transaction model checked every cycle plus literal word lists.
module tb_fc_ibuf_stream;
  localparam int DS = 4;
  localparam int NC = 2;
  localparam int FL = 3;
  localparam int BW = 4;
  localparam int NE = NC * FL;
  localparam int NA = (NE + BW - 1) / BW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fc_ibuf_stream_if #(.DATA_SIZE(DS), .NUM_CHANNELS(NC), .FIFO_LENGTH(FL), .BUS_WIDTH(BW)) bus();

  fc_ibuf_stream #(.DATA_SIZE(DS), .NUM_CHANNELS(NC), .FIFO_LENGTH(FL), .BUS_WIDTH(BW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0] data;
    int         addr;
    int         plane;
    logic       msb;
    logic       last;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       q[$];
  logic [3:0] m_elem [NE];
  int         m_beats;
  bit         m_fill;
  logic [3:0] log_q[$];
  int         hs_cnt;

  logic [3:0] exp_basic [8] = '{4'b0101, 4'b0001, 4'b0110, 4'b0010, 4'b1000, 4'b0011, 4'b0000, 4'b0000};
  logic [3:0] exp_bp    [8] = '{4'b1011, 4'b0010, 4'b1101, 4'b0000, 4'b0001, 4'b0011, 4'b0110, 4'b0001};
  logic [3:0] exp_ones  [8] = '{4'b1111, 4'b0011, 4'b1111, 4'b0011, 4'b1111, 4'b0011, 4'b1111, 4'b0011};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected word sequence of one transaction, plane-major, from the stored elements.
  function automatic void build_q();
    exp_t e;
    int   idx;
    q.delete();
    for (int p = 0; p < DS; p++) begin
      for (int a = 0; a < NA; a++) begin
        e.data = 4'b0000;
        for (int b = 0; b < BW; b++) begin
          idx = a * BW + b;
          if (idx < NE) e.data[b] = m_elem[idx][p];
        end
        e.addr  = a;
        e.plane = p;
        e.msb   = (p == DS - 1);
        e.last  = (p == DS - 1) && (a == NA - 1);
        q.push_back(e);
      end
    end
  endfunction

  // Transaction model: advances on each clock edge using the inputs the DUT sampled.
  initial begin
    m_fill  = 1'b1;
    m_beats = 0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_fill = 1'b1; m_beats = 0; q.delete();
      end else if (bus.i_clear) begin
        m_fill = 1'b1; m_beats = 0; q.delete();
      end else if (m_fill) begin
        if (bus.i_valid) begin
          for (int c = 0; c < NC; c++) m_elem[m_beats*NC + c] = bus.i_data[c*DS +: DS];
          m_beats++;
          if (m_beats == FL) begin
            build_q();
            m_fill  = 1'b0;
            m_beats = 0;
          end
        end
      end else if (bus.i_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        if (q.size() == 0) m_fill = 1'b1;
      end
    end
  end

  // Compare process on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("rst_ready", bus.o_ready, 1);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_addr", bus.o_addr, 0);
        chk("rst_plane", bus.o_plane, 0);
        chk("rst_data", bus.o_data, 0);
        chk("rst_msb", bus.o_msb_plane, 0);
        chk("rst_last", bus.o_last, 0);
      end else begin
        chk("ready", bus.o_ready, m_fill);
        chk("valid", bus.o_valid, !m_fill);
        if (!m_fill) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL model_empty actual=streaming expected=fill");
          end else begin
            chk("data", bus.o_data, q[0].data);
            chk("addr", bus.o_addr, q[0].addr);
            chk("plane", bus.o_plane, q[0].plane);
            chk("msb_plane", bus.o_msb_plane, q[0].msb);
            chk("last", bus.o_last, q[0].last);
          end
        end
        if (bus.o_valid && bus.i_ready) begin
          log_q.push_back(bus.o_data);
          hs_cnt++;
        end
      end
    end
  end

  task automatic beat(input logic [3:0] c0, input logic [3:0] c1);
    bus.i_valid = 1'b1;
    bus.i_data  = {c1, c0};
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!m_fill && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_fill) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  task automatic wait_plane_addr(input int p, input int a);
    int n = 0;
    while (!(bus.o_valid && int'(bus.o_plane) == p && int'(bus.o_addr) == a) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL position_timeout actual=not_reached expected=plane%0d_addr%0d", p, a);
    end
  endtask

  task automatic check_log(input string name, input logic [3:0] exp [8]);
    chk({name, "_len"}, log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) chk(name, log_q[i], exp[i]);
  endtask

  task automatic rst_pulse();
    #2 rstn = 1'b0;
    #1;
    chk("arst_ready", bus.o_ready, 1);
    chk("arst_valid", bus.o_valid, 0);
    chk("arst_addr", bus.o_addr, 0);
    chk("arst_plane", bus.o_plane, 0);
    chk("arst_data", bus.o_data, 0);
    chk("arst_last", bus.o_last, 0);
    @(posedge clk); #2;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;
    bus.i_clear = 1'b0;
    bus.i_ready = 1'b1;
    hs_cnt      = 0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk); #1;

    // basic fill and stream
    log_q.delete();
    beat(4'd1, 4'd2); beat(4'd3, 4'd4); beat(4'd5, 4'd6);
    chk("valid_no_bubble", bus.o_valid, 1);
    wait_idle();
    check_log("basic", exp_basic);
    chk("ready_returns", bus.o_ready, 1);

    // backpressure at plane 1, addr 1
    log_q.delete(); hs_cnt = 0;
    beat(4'd7, 4'd9); beat(4'd10, 4'd3); beat(4'd12, 4'd5);
    wait_plane_addr(1, 1);
    bus.i_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.i_ready = 1'b1;
    wait_idle();
    chk("bp_handshakes", hs_cnt, 8);
    check_log("bp", exp_bp);

    // write attempt during stream is ignored
    log_q.delete();
    beat(4'd1, 4'd2); beat(4'd3, 4'd4); beat(4'd5, 4'd6);
    bus.i_valid = 1'b1; bus.i_data = 8'hFF;
    repeat (4) @(posedge clk);
    #1 chk("ready_low_stream", bus.o_ready, 0);
    bus.i_valid = 1'b0;
    wait_idle();
    check_log("ignored_write", exp_basic);

    // clear together with a handshake at plane 2
    beat(4'd1, 4'd2); beat(4'd3, 4'd4); beat(4'd5, 4'd6);
    wait_plane_addr(2, 0);
    bus.i_clear = 1'b1;
    @(posedge clk); #1;
    bus.i_clear = 1'b0;
    chk("clr_ready", bus.o_ready, 1);
    chk("clr_valid", bus.o_valid, 0);
    chk("clr_plane", bus.o_plane, 0);
    log_q.delete();
    beat(4'd15, 4'd15); beat(4'd15, 4'd15); beat(4'd15, 4'd15);
    wait_idle();
    check_log("after_clear", exp_ones);

    // async reset mid-fill
    log_q.delete();
    beat(4'd15, 4'd15); beat(4'd15, 4'd15);
    rst_pulse();
    beat(4'd1, 4'd2); beat(4'd3, 4'd4);
    chk("no_valid_after_2", bus.o_valid, 0);
    beat(4'd5, 4'd6);
    chk("valid_after_3", bus.o_valid, 1);
    wait_idle();
    check_log("rst_fill", exp_basic);

    // async reset mid-stream
    beat(4'd1, 4'd2); beat(4'd3, 4'd4); beat(4'd5, 4'd6);
    repeat (3) @(posedge clk);
    #1;
    rst_pulse();
    log_q.delete();
    beat(4'd15, 4'd15); beat(4'd15, 4'd15); beat(4'd15, 4'd15);
    wait_idle();
    check_log("rst_stream", exp_ones);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fc_ibuf_stream.md
FC_IBUF_STREAM -- requirements
Module: fc_ibuf_stream

Interface
- REQ-001: Parameter DATA_SIZE, default 8: bits per activation element.
- REQ-002: Parameter NUM_CHANNELS, default 4: elements accepted per write beat.
- REQ-003: Parameter FIFO_LENGTH, default 32: write beats per full buffer.
- REQ-004: Parameter BUS_WIDTH, default 16: crossbar input word width in bits.
- REQ-005: Derived: ELEMENTS = NUM_CHANNELS*FIFO_LENGTH; NUM_ADDR = ceil(ELEMENTS/BUS_WIDTH); ADDR_W = max(1, clog2(NUM_ADDR)); PLANE_W = max(1, clog2(DATA_SIZE)).
- REQ-006: Clocking is fixed: one clock; reset is asynchronous and active-low.
- REQ-007: clk  in  1  rising-edge clock.
- REQ-008: rstn  in  1  asynchronous active-low reset.
- REQ-009: i_valid  in  1  write beat valid.
- REQ-010: o_ready  out  1  buffer can accept a write beat.
- REQ-011: i_data  in  NUM_CHANNELS*DATA_SIZE  beat payload; channel c occupies bits [c*DATA_SIZE +: DATA_SIZE].
- REQ-012: i_clear  in  1  synchronous flush.
- REQ-013: o_valid  out  1  output word valid.
- REQ-014: i_ready  in  1  downstream accepts the output word.
- REQ-015: o_data  out  BUS_WIDTH  current bit-plane word.
- REQ-016: o_addr  out  ADDR_W  word index within the plane.
- REQ-017: o_plane  out  PLANE_W  bit index being emitted, 0 = LSB.
- REQ-018: o_msb_plane  out  1  high while o_plane == DATA_SIZE-1, for signed subtraction downstream.
- REQ-019: o_last  out  1  high on the final word of the final plane.

Function
- REQ-020: The block has two states: FILL (o_ready=1, o_valid=0) and STREAM (o_ready=0, o_valid=1).
- REQ-021: In FILL, a beat is accepted when i_valid && o_ready; beat n (0-based) stores channel c as element e = n*NUM_CHANNELS + c.
- REQ-022: A beat counter (0..FIFO_LENGTH-1) increments per accepted beat.
- REQ-023: Accepting beat FIFO_LENGTH-1 moves the block to STREAM on the next edge, with o_addr=0, o_plane=0 and the beat counter cleared.
- REQ-024: In STREAM, bit b of o_data equals bit o_plane of element o_addr*BUS_WIDTH + b.
- REQ-025: Bits whose element index is >= ELEMENTS are 0.
- REQ-026: o_data, o_addr, o_plane, o_msb_plane and o_last hold stable while o_valid && !i_ready.
- REQ-027: On each handshake (o_valid && i_ready):
  - o_addr increments;
  - if o_addr == NUM_ADDR-1, o_addr wraps to 0 and o_plane increments.
- REQ-028: A handshake while o_last=1 (o_addr == NUM_ADDR-1 and o_plane == DATA_SIZE-1) returns the block to FILL on the next edge, with o_addr and o_plane reset to 0.
- REQ-029: Stored data is not modified during STREAM.
- REQ-030: A new fill overwrites stored elements in place; old content is never emitted after refill.
- REQ-031: One full transaction takes exactly FIFO_LENGTH write beats and DATA_SIZE*NUM_ADDR output handshakes.
- REQ-032: Write throughput is 1 beat/cycle; output throughput is 1 word/cycle under continuous i_ready.
- REQ-033: There is no bubble cycle between the last accepted beat and o_valid=1.
- REQ-034: i_valid is ignored in STREAM; i_ready is ignored in FILL.
- REQ-035: i_clear has priority over every other event in the same cycle. On the next edge:
  - state = FILL;
  - beat counter, o_addr and o_plane = 0;
  - storage contents are don't-care.
- REQ-036: When DATA_SIZE == 1, o_msb_plane is constantly high during STREAM.
- REQ-037: When ELEMENTS is not a multiple of BUS_WIDTH, the final word of each plane is zero-padded per REQ-025.

Reset
- REQ-038: While rstn=0, all of the following hold asynchronously:
  - state = FILL;
  - o_ready = 1 and o_valid = 0;
  - o_addr, o_plane and the beat counter = 0;
  - o_data, o_msb_plane and o_last = 0.
- REQ-039: Storage registers need not be reset.
- REQ-040: Reset asserted mid-STREAM aborts the transaction; the first beat after deassertion is stored as beat 0.
- REQ-041: Deassertion takes effect at the first rising clk edge after rstn rises.

Verification (bench configuration: DATA_SIZE=4, NUM_CHANNELS=2, FIFO_LENGTH=3, BUS_WIDTH=4; so ELEMENTS=6, NUM_ADDR=2)
- REQ-042: Basic fill and stream:
  - stimulus: beats {1,2},{3,4},{5,6}, i_ready=1;
  - response: o_valid rises the cycle after beat 3;
  - plane 0: words 0101, 0001 (element 0 at bit 0);
  - plane 1: 0110, 0010; plane 2: 1000, 0011;
  - plane 3: 0000, 0000, with o_last on the 8th word;
  - o_ready returns the next cycle.
- REQ-043: Backpressure:
  - stimulus: hold i_ready=0 for 5 cycles at plane 1, addr 1;
  - response: outputs held constant; total handshakes still 8.
- REQ-044: Ignored write during STREAM:
  - stimulus: i_valid=1 with data 15 during STREAM;
  - response: o_ready=0 and the emitted words are unchanged.
- REQ-045: Clear with simultaneous handshake:
  - stimulus: i_clear asserted together with a handshake at plane 2;
  - response: next cycle o_ready=1, o_valid=0, o_plane=0;
  - a fresh fill of all 15s emits 1111, 0011 on all 4 planes.
- REQ-046: Asynchronous reset mid-transaction:
  - stimulus: rstn pulsed low mid-fill (after 2 beats) and again mid-stream;
  - response: outputs reach reset values without a clock edge;
  - 3 further beats are required before o_valid asserts.
